uart_tx_ctrl: RTL

UART transmit controller for the serial link.
- Accepts bytes over a valid/ready handshake and serialises each one onto the tx line: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Generates its own bit timing from the system clock with an internal baud counter.
- Sits between the byte source (host logic / FIFO) and the tx pad.

---
 rtl/uart_tx_ctrl_pkg.sv | 19 +
 rtl/uart_tx_ctrl_if.sv | 28 ++
 rtl/uart_tx_ctrl_baud_tick.sv | 26 ++
 rtl/uart_tx_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: tx state encoding, data width, bit-timing helper.
// Used by the transmit controller and intended for reuse by the receive side.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-source to UART transmitter bundle: valid/ready byte handshake plus line and status.
// The source drives tx_data/tx_valid; the transmitter drives tx_ready, tx and busy.
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx,
        output busy
    );

endinterface

// File: rtl/uart_tx_ctrl_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count for one cycle.
// clr restarts the period so the first bit of a frame gets its full width.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits; start bit on line one cycle after accept.
// tx_ready is high only in IDLE, so the source is stalled for the whole frame; valid while busy is ignored.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave bus
);
    // Must come out >= 2 for the baud counter to have a distinct terminal count.
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 accept;
    logic                 tick;

    assign bus.tx_ready = (state_q == IDLE);
    assign accept       = bus.tx_valid && (state_q == IDLE);
    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d    = bus.tx_data;
                    par_d      = (^bus.tx_data) ^ 1'(PARITY_ODD);
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so tx comes straight off a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule
